// File: rtl/cpu_exec_commit_if.sv
// Bundle of the ALU-side op, writeback beat and fetch redirect signals of the
// commit stage. The slave view belongs to the stage, the master view to its neighbours.
interface cpu_exec_commit_if #(
  parameter int XLEN = 32
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] alu_res_i;
  logic            cmp_eq_i;
  logic            cmp_lt_i;
  logic [2:0]      funct3_i;
  logic            is_branch_i;
  logic            is_jal_i;
  logic            is_jalr_i;
  logic [4:0]      rd_i;
  logic            wr_en_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [4:0]      out_rd_o;
  logic [XLEN-1:0] out_data_o;
  logic            out_wr_en_o;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            misalign_o;

  modport slave (
    input  in_valid_i, pc_i, imm_i, alu_res_i, cmp_eq_i, cmp_lt_i, funct3_i,
           is_branch_i, is_jal_i, is_jalr_i, rd_i, wr_en_i, out_ready_i,
    output in_ready_o, out_valid_o, out_rd_o, out_data_o, out_wr_en_o,
           redirect_valid_o, redirect_pc_o, misalign_o
  );

  modport master (
    output in_valid_i, pc_i, imm_i, alu_res_i, cmp_eq_i, cmp_lt_i, funct3_i,
           is_branch_i, is_jal_i, is_jalr_i, rd_i, wr_en_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_rd_o, out_data_o, out_wr_en_o,
           redirect_valid_o, redirect_pc_o, misalign_o
  );
endinterface

// File: rtl/cpu_exec_commit.sv
// Execute/commit stage: resolves branches and jumps, forms the writeback beat and
// buffers it in a main + skid register pair; pulses a fetch redirect or misalign flag.
module cpu_exec_commit #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  cpu_exec_commit_if.slave  bus
);

  logic            main_valid_q, main_valid_d;
  logic [4:0]      main_rd_q, main_rd_d;
  logic [XLEN-1:0] main_data_q, main_data_d;
  logic            main_we_q, main_we_d;
  logic            skid_valid_q, skid_valid_d;
  logic [4:0]      skid_rd_q, skid_rd_d;
  logic [XLEN-1:0] skid_data_q, skid_data_d;
  logic            skid_we_q, skid_we_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            misalign_q, misalign_d;
  logic            in_ready_q, in_ready_d;

  logic            accept;
  logic            is_jump;
  logic            br_cond;
  logic            taken;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] target;
  logic            mis_now;
  logic [XLEN-1:0] wb_data;
  logic            wb_we;
  logic            push;
  logic            drain;

  always_comb begin
    accept  = bus.in_valid_i && in_ready_q;
    is_jump = bus.is_jal_i || bus.is_jalr_i;
    case (bus.funct3_i)
      3'b000:         br_cond = bus.cmp_eq_i;
      3'b001:         br_cond = !bus.cmp_eq_i;
      3'b100, 3'b110: br_cond = bus.cmp_lt_i;
      3'b101, 3'b111: br_cond = !bus.cmp_lt_i;
      default:        br_cond = 1'b0;
    endcase
    taken      = is_jump || (bus.is_branch_i && br_cond);
    raw_target = bus.is_jalr_i ? bus.alu_res_i : bus.pc_i + bus.imm_i;
    target     = {raw_target[XLEN-1:1], 1'b0};
    // A target with bit 1 set cannot be fetched; the beat still retires, without writing rd.
    mis_now    = taken && target[1];
    wb_data    = is_jump ? bus.pc_i + XLEN'(4) : bus.alu_res_i;
    wb_we      = bus.wr_en_i && (bus.rd_i != 5'd0) && !mis_now;
    push       = accept && !bus.is_branch_i;
    drain      = main_valid_q && bus.out_ready_i;
  end

  always_comb begin
    main_valid_d = main_valid_q;
    main_rd_d    = main_rd_q;
    main_data_d  = main_data_q;
    main_we_d    = main_we_q;
    skid_valid_d = skid_valid_q;
    skid_rd_d    = skid_rd_q;
    skid_data_d  = skid_data_q;
    skid_we_d    = skid_we_q;
    if (!main_valid_q || drain) begin
      // Skid is only occupied while in_ready is low, so it never competes with push.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_rd_d    = skid_rd_q;
        main_data_d  = skid_data_q;
        main_we_d    = skid_we_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        main_valid_d = 1'b1;
        main_rd_d    = bus.rd_i;
        main_data_d  = wb_data;
        main_we_d    = wb_we;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_rd_d    = bus.rd_i;
      skid_data_d  = wb_data;
      skid_we_d    = wb_we;
    end
  end

  always_comb begin
    redirect_valid_d = accept && taken && !mis_now;
    misalign_d       = accept && mis_now;
    redirect_pc_d    = (accept && taken) ? target : redirect_pc_q;
    in_ready_d       = !skid_valid_d && !redirect_valid_d && !misalign_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q     <= 1'b0;
      main_rd_q        <= '0;
      main_data_q      <= '0;
      main_we_q        <= 1'b0;
      skid_valid_q     <= 1'b0;
      skid_rd_q        <= '0;
      skid_data_q      <= '0;
      skid_we_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      misalign_q       <= 1'b0;
      in_ready_q       <= 1'b0;
    end else begin
      main_valid_q     <= main_valid_d;
      main_rd_q        <= main_rd_d;
      main_data_q      <= main_data_d;
      main_we_q        <= main_we_d;
      skid_valid_q     <= skid_valid_d;
      skid_rd_q        <= skid_rd_d;
      skid_data_q      <= skid_data_d;
      skid_we_q        <= skid_we_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      misalign_q       <= misalign_d;
      in_ready_q       <= in_ready_d;
    end
  end

  assign bus.in_ready_o       = in_ready_q;
  assign bus.out_valid_o      = main_valid_q;
  assign bus.out_rd_o         = main_rd_q;
  assign bus.out_data_o       = main_data_q;
  assign bus.out_wr_en_o      = main_we_q;
  assign bus.redirect_valid_o = redirect_valid_q;
  assign bus.redirect_pc_o    = redirect_pc_q;
  assign bus.misalign_o       = misalign_q;

endmodule

// File: tb/tb_cpu_exec_commit.sv
// Randomized bench for cpu_exec_commit against a queue-based model of the
// writeback stream and the redirect/misalign pulses.
module tb_cpu_exec_commit;

  localparam int K_ALU = 0, K_BR = 1, K_JAL = 2, K_JALR = 3;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } beat_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  cpu_exec_commit_if bus_if ();

  cpu_exec_commit dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus_if)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  beat_t       exp_q[$];
  bit          exp_ready = 0;
  bit          exp_redir = 0;
  bit          exp_mis = 0;
  logic [31:0] exp_rpc = 32'h0;

  bit          cur_v;
  int          cur_kind;
  logic [31:0] cur_pc, cur_imm, cur_alu;
  bit          cur_eq, cur_lt, cur_we;
  logic [2:0]  cur_f3;
  logic [4:0]  cur_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit br_taken(input logic [2:0] f3, input bit eq, input bit lt);
    case (f3)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic set_op(input bit v, input int kind, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] alu, input bit eq, input bit lt, input logic [2:0] f3,
                        input logic [4:0] rd, input bit we);
    cur_v = v; cur_kind = kind; cur_pc = pc; cur_imm = imm; cur_alu = alu;
    cur_eq = eq; cur_lt = lt; cur_f3 = f3; cur_rd = rd; cur_we = we;
    bus_if.in_valid_i  = v;
    bus_if.pc_i        = pc;
    bus_if.imm_i       = imm;
    bus_if.alu_res_i   = alu;
    bus_if.cmp_eq_i    = eq;
    bus_if.cmp_lt_i    = lt;
    bus_if.funct3_i    = f3;
    bus_if.is_branch_i = (kind == K_BR);
    bus_if.is_jal_i    = (kind == K_JAL);
    bus_if.is_jalr_i   = (kind == K_JALR);
    bus_if.rd_i        = rd;
    bus_if.wr_en_i     = we;
  endtask

  task automatic idle();
    set_op(1'b0, K_ALU, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
  endtask

  task automatic check_outputs();
    chk("in_ready", {31'b0, bus_if.in_ready_o}, {31'b0, exp_ready});
    chk("out_valid", {31'b0, bus_if.out_valid_o}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk("out_rd", {27'b0, bus_if.out_rd_o}, {27'b0, exp_q[0].rd});
      chk("out_data", bus_if.out_data_o, exp_q[0].data);
      chk("out_wr_en", {31'b0, bus_if.out_wr_en_o}, {31'b0, exp_q[0].we});
    end
    chk("redirect_valid", {31'b0, bus_if.redirect_valid_o}, {31'b0, exp_redir});
    chk("misalign", {31'b0, bus_if.misalign_o}, {31'b0, exp_mis});
    if (exp_redir || exp_mis) chk("redirect_pc", bus_if.redirect_pc_o, exp_rpc);
  endtask

  // Advance one clock: update the model from the presented op, then compare after the edge.
  task automatic tick(input bit oready);
    bit          acc, jump, tk;
    logic [31:0] tgt;
    beat_t       b;
    bus_if.out_ready_i = oready;
    acc  = cur_v && exp_ready;
    jump = (cur_kind == K_JAL) || (cur_kind == K_JALR);
    tk   = jump || (cur_kind == K_BR && br_taken(cur_f3, cur_eq, cur_lt));
    tgt  = (cur_kind == K_JALR) ? cur_alu : cur_pc + cur_imm;
    tgt[0] = 1'b0;
    exp_redir = acc && tk && !tgt[1];
    exp_mis   = acc && tk && tgt[1];
    if (acc && tk) exp_rpc = tgt;
    if (exp_q.size() != 0 && oready) void'(exp_q.pop_front());
    if (acc && cur_kind != K_BR) begin
      b.rd   = cur_rd;
      b.data = jump ? cur_pc + 32'd4 : cur_alu;
      b.we   = cur_we && (cur_rd != 5'd0) && !(tk && tgt[1]);
      exp_q.push_back(b);
    end
    exp_ready = (exp_q.size() < 2) && !exp_redir && !exp_mis;
    @(posedge clk_i);
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ready = 0;
    exp_redir = 0;
    exp_mis   = 0;
    exp_rpc   = 32'h0;
  endtask

  initial begin
    idle();
    bus_if.out_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_out_valid", {31'b0, bus_if.out_valid_o}, 32'd0);
    chk("rst_redirect", {31'b0, bus_if.redirect_valid_o}, 32'd0);
    chk("rst_redirect_pc", bus_if.redirect_pc_o, 32'd0);
    rst_ni = 1'b1;
    tick(1'b1);
    chk("ready_after_reset", {31'b0, bus_if.in_ready_o}, 32'd1);

    // Taken BEQ
    set_op(1'b1, K_BR, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 3'b000, 5'd7, 1'b1);
    tick(1'b1);
    chk("beq_target", bus_if.redirect_pc_o, 32'h120);
    idle(); tick(1'b1);

    // BNE with eq=1, then funct3=010: neither taken
    set_op(1'b1, K_BR, 32'h200, 32'h40, 32'h0, 1'b1, 1'b0, 3'b001, 5'd7, 1'b1);
    tick(1'b1);
    set_op(1'b1, K_BR, 32'h204, 32'h40, 32'h0, 1'b1, 1'b1, 3'b010, 5'd7, 1'b1);
    tick(1'b1);
    chk("nt_ready", {31'b0, bus_if.in_ready_o}, 32'd1);
    idle(); tick(1'b1);

    // Misaligned JALR still retires a beat, with the write suppressed
    set_op(1'b1, K_JALR, 32'h40, 32'h0, 32'h2003, 1'b0, 1'b0, 3'd0, 5'd1, 1'b1);
    tick(1'b1);
    chk("jalr_pc", bus_if.redirect_pc_o, 32'h2002);
    chk("jalr_wr_en", {31'b0, bus_if.out_wr_en_o}, 32'd0);
    idle(); tick(1'b1);

    // JAL wrapping at the top of the address space
    set_op(1'b1, K_JAL, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b0, 1'b0, 3'd0, 5'd5, 1'b1);
    tick(1'b1);
    chk("jal_pc", bus_if.redirect_pc_o, 32'h4);
    chk("jal_data", bus_if.out_data_o, 32'h0);
    idle(); tick(1'b1);

    // Three ALU ops into a stalled consumer, then release
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, K_ALU, 32'h300 + 32'(4 * i), 32'h0, 32'hA000 + 32'(i), 1'b0, 1'b0, 3'd0,
             5'(i + 2), 1'b1);
      tick(1'b0);
    end
    chk("full_ready", {31'b0, bus_if.in_ready_o}, 32'd0);
    idle();
    repeat (4) tick(1'b1);

    // Async reset with a beat held and a redirect pending
    set_op(1'b1, K_JAL, 32'h500, 32'h10, 32'h0, 1'b0, 1'b0, 3'd0, 5'd3, 1'b1);
    tick(1'b0);
    idle();
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("arst_redirect_pc", bus_if.redirect_pc_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick(1'b1);
    chk("arst_ready", {31'b0, bus_if.in_ready_o}, 32'd1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int          k;
      logic [31:0] pc, imm;
      k   = int'($urandom_range(0, 3));
      pc  = $urandom & 32'hFFFF_FFFC;
      imm = $urandom_range(0, 1) != 0 ? ($urandom & 32'h0000_0FFE) : ($urandom | 32'hFFFF_F000) & 32'hFFFF_FFFE;
      set_op($urandom_range(0, 9) < 7, k, pc, imm, $urandom, 1'($urandom), 1'($urandom),
             3'($urandom), $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom), 1'($urandom));
      tick($urandom_range(0, 9) < 6);
    end
    idle();
    repeat (4) tick(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
